// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    // Sequencer states; the encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_e;

    // Byte distance between consecutive instructions.
    localparam int unsigned PC_STEP = 32'd4;

    // Low address bits that must be zero for a legal instruction address.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // True when the low address bits place the target off a word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return ((addr_lo & ALIGN_MASK) != 2'b00);
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory and datapath handshake bundle of the sequencer.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    import pc_seq_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            exec_done;
    logic            halt;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    // Sequencer side.
    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, exec_done, halt,
               jump, jump_target, branch_taken, branch_target
    );

    // Memory / datapath side.
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, exec_done, halt,
               jump, jump_target, branch_taken, branch_target
    );
endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Next-PC selection: halt > jump > branch > sequential, with a flag for
// redirect targets that are not word aligned.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            halt,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic redirect_s;

    // Priority mux; only redirect targets can be misaligned since pc+4 keeps alignment.
    always_comb begin
        next_pc    = pc + XLEN'(PC_STEP);
        redirect_s = 1'b0;
        if (halt) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc    = jump_target;
            redirect_s = 1'b1;
        end else if (branch_taken) begin
            next_pc    = branch_target;
            redirect_s = 1'b1;
        end else begin
            next_pc = pc + XLEN'(PC_STEP);
        end
        misaligned = redirect_s & is_misaligned(next_pc[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer owning the program counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [XLEN-1:0]   start_pc,
    input  logic              run,
    pc_sequencer_if.master    bus,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       retired,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        state
);

    // Timer only needs to hold 0 .. FETCH_TIMEOUT-1.
    localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(FETCH_TIMEOUT - 1);

    seq_state_e      state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [31:0]     retired_r, retired_nxt_s;
    logic [XLEN-1:0] instr_r, instr_nxt_s;
    logic            instr_valid_r, instr_valid_nxt_s;
    logic [TW-1:0]   timer_r, timer_nxt_s;
    logic            req_r, halted_r, fault_r;
    logic [XLEN-1:0] sel_pc_s;
    logic            misaligned_s;

    pc_next_sel #(.XLEN(XLEN)) u_next_sel (
        .pc            (pc_r),
        .halt          (bus.halt),
        .jump          (bus.jump),
        .jump_target   (bus.jump_target),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .next_pc       (sel_pc_s),
        .misaligned    (misaligned_s)
    );

    // Next-state, PC, retire count, fetch timer and instruction latch decisions.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        retired_nxt_s     = retired_r;
        instr_nxt_s       = instr_r;
        instr_valid_nxt_s = 1'b0;
        timer_nxt_s       = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An ack on the last allowed cycle still completes the fetch.
                if (bus.imem_ack) begin
                    instr_nxt_s       = bus.imem_rdata;
                    instr_valid_nxt_s = 1'b1;
                    timer_nxt_s       = {TW{1'b0}};
                    state_nxt_s       = ST_EXEC;
                end else if (timer_r == TIMER_LAST) begin
                    state_nxt_s = ST_FAULT;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            ST_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.halt) begin
                        retired_nxt_s = retired_r + 32'd1;
                        state_nxt_s   = ST_HALTED;
                    end else if (misaligned_s) begin
                        state_nxt_s = ST_FAULT;
                    end else begin
                        pc_nxt_s      = sel_pc_s;
                        retired_nxt_s = retired_r + 32'd1;
                        state_nxt_s   = ST_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            ST_FAULT:  state_nxt_s = ST_FAULT;
            default:   state_nxt_s = ST_FAULT;
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r       <= ST_IDLE;
            pc_r          <= start_pc;
            retired_r     <= 32'd0;
            instr_r       <= {XLEN{1'b0}};
            instr_valid_r <= 1'b0;
            timer_r       <= {TW{1'b0}};
            req_r         <= 1'b0;
            halted_r      <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            retired_r     <= retired_nxt_s;
            instr_r       <= instr_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
            timer_r       <= timer_nxt_s;
            req_r         <= (state_nxt_s == ST_FETCH);
            halted_r      <= (state_nxt_s == ST_HALTED);
            fault_r       <= (state_nxt_s == ST_FAULT);
        end
    end

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = pc_r;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = instr_valid_r;
    assign pc              = pc_r;
    assign retired         = retired_r;
    assign halted          = halted_r;
    assign fault           = fault_r;
    assign state           = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    localparam int FT = 16;
    localparam int S_IDLE = 0, S_FETCH = 1, S_EXEC = 2, S_HALTED = 3, S_FAULT = 4;

    logic        CLK;
    logic        RESET;
    logic [31:0] start_pc;
    logic        run;
    logic [31:0] pc;
    logic [31:0] retired;
    logic        halted;
    logic        fault;
    logic [2:0]  state;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32), .FETCH_TIMEOUT(FT)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start_pc (start_pc),
        .run      (run),
        .bus      (bus),
        .pc       (pc),
        .retired  (retired),
        .halted   (halted),
        .fault    (fault),
        .state    (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    // Model of the sequencer: where it is, which address it fetches, what it holds.
    bit          m_valid = 1'b0;
    int          m_state;
    logic [31:0] m_pc, m_instr, m_ret;
    logic        m_iv;
    int          m_fetch_wait;

    logic [31:0] addr_q[$];
    int          iv_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Effect of the coming rising edge, from the rules of operation.
    task automatic model_step();
        logic [31:0] tgt;
        if (!RESET) begin
            m_valid = 1'b1; m_state = S_IDLE; m_pc = start_pc; m_instr = 32'd0;
            m_iv = 1'b0; m_ret = 32'd0; m_fetch_wait = 0;
            return;
        end
        if (!m_valid) return;
        m_iv = 1'b0;
        if (m_state == S_IDLE) begin
            if (run) m_state = S_FETCH;
        end else if (m_state == S_FETCH) begin
            if (bus.imem_ack) begin
                m_instr = bus.imem_rdata; m_iv = 1'b1; m_fetch_wait = 0; m_state = S_EXEC;
            end else begin
                m_fetch_wait++;
                if (m_fetch_wait >= FT) m_state = S_FAULT;
            end
        end else if (m_state == S_EXEC && bus.exec_done) begin
            if (bus.halt) begin
                m_ret++; m_state = S_HALTED;
            end else if (bus.jump || bus.branch_taken) begin
                tgt = bus.jump ? bus.jump_target : bus.branch_target;
                if (tgt % 4 != 0) m_state = S_FAULT;
                else begin m_pc = tgt; m_ret++; m_state = S_FETCH; end
            end else begin
                m_pc = m_pc + 32'd4; m_ret++; m_state = S_FETCH;
            end
        end
    endtask

    task automatic check_outputs();
        if (m_valid) begin
            check_val("state", 32'(state), 32'(m_state));
            check_val("imem_req", 32'(bus.imem_req), 32'(m_state == S_FETCH));
            check_val("imem_addr", bus.imem_addr, m_pc);
            check_val("pc", pc, m_pc);
            check_val("instr", bus.instr, m_instr);
            check_val("instr_valid", 32'(bus.instr_valid), 32'(m_iv));
            check_val("retired", retired, m_ret);
            check_val("halted", 32'(halted), 32'(m_state == S_HALTED));
            check_val("fault", 32'(fault), 32'(m_state == S_FAULT));
        end
    endtask

    // Inputs are set just after a falling edge; advance one clock and check.
    task automatic tick();
        model_step();
        @(negedge CLK);
        check_outputs();
        if (bus.imem_req) addr_q.push_back(bus.imem_addr);
        if (bus.instr_valid) iv_cnt++;
    endtask

    task automatic clear_ctl();
        run = 1'b0; bus.imem_ack = 1'b0; bus.exec_done = 1'b0; bus.halt = 1'b0;
        bus.jump = 1'b0; bus.branch_taken = 1'b0;
        bus.jump_target = 32'd0; bus.branch_target = 32'd0;
        bus.imem_rdata = $urandom;
    endtask

    task automatic do_reset(input logic [31:0] spc);
        clear_ctl();
        start_pc = spc; RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    // IDLE -> FETCH -> EXEC with an immediate ack.
    task automatic to_exec();
        run = 1'b1; bus.imem_ack = 1'b1;
        tick(); tick();
    endtask

    int ack_pct;

    initial begin
        RESET = 1'b1; start_pc = 32'd0;
        clear_ctl();
        @(negedge CLK);

        // Reset state and sequential run.
        do_reset(32'h0000_0100);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_pc", pc, 32'h0000_0100);
        check_val("rst_retired", retired, 32'd0);
        check_val("rst_iv", 32'(bus.instr_valid), 32'd0);
        addr_q.delete(); iv_cnt = 0;
        run = 1'b1; bus.imem_ack = 1'b1; bus.exec_done = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.imem_rdata = $urandom;
            tick();
        end
        check_val("seq_nfetch", 32'(addr_q.size()), 32'd4);
        if (addr_q.size() >= 3) begin
            check_val("seq_addr0", addr_q[0], 32'h0000_0100);
            check_val("seq_addr1", addr_q[1], 32'h0000_0104);
            check_val("seq_addr2", addr_q[2], 32'h0000_0108);
        end
        check_val("seq_retired", retired, 32'd3);
        check_val("seq_ivcount", 32'(iv_cnt), 32'd3);

        // Jump beats branch, then branch alone.
        do_reset(32'h0000_0200);
        to_exec();
        bus.exec_done = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0400;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0300;
        tick();
        check_val("jump_prio_addr", bus.imem_addr, 32'h0000_0400);
        bus.exec_done = 1'b0; bus.jump = 1'b0; bus.branch_taken = 1'b0;
        tick();
        bus.exec_done = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0300;
        tick();
        check_val("branch_addr", bus.imem_addr, 32'h0000_0300);
        check_val("branch_req", 32'(bus.imem_req), 32'd1);

        // Halt beats jump.
        do_reset(32'h0000_0200);
        to_exec();
        bus.exec_done = 1'b1; bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0400;
        tick();
        check_val("halt_flag", 32'(halted), 32'd1);
        check_val("halt_pc", pc, 32'h0000_0200);
        check_val("halt_retired", retired, 32'd1);
        clear_ctl(); run = 1'b1; bus.imem_ack = 1'b1;
        tick(); tick();
        check_val("halt_noreq", 32'(bus.imem_req), 32'd0);

        // Misaligned jump target.
        do_reset(32'h0000_0200);
        to_exec();
        bus.exec_done = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0402;
        tick();
        check_val("misal_fault", 32'(fault), 32'd1);
        check_val("misal_pc", pc, 32'h0000_0200);
        check_val("misal_retired", retired, 32'd0);

        // Ack on the last allowed fetch cycle.
        do_reset(32'h0000_0500);
        run = 1'b1;
        tick();
        for (int i = 0; i < FT - 1; i++) tick();
        bus.imem_ack = 1'b1;
        tick();
        check_val("late_ack_state", 32'(state), 32'd2);
        check_val("late_ack_fault", 32'(fault), 32'd0);

        // No ack at all.
        do_reset(32'h0000_0500);
        run = 1'b1;
        tick();
        for (int i = 0; i < FT - 1; i++) tick();
        check_val("tmo_pre_fault", 32'(fault), 32'd0);
        check_val("tmo_pre_req", 32'(bus.imem_req), 32'd1);
        tick();
        check_val("tmo_fault", 32'(fault), 32'd1);
        check_val("tmo_req", 32'(bus.imem_req), 32'd0);

        // Address wrap.
        do_reset(32'hFFFF_FFFC);
        to_exec();
        bus.exec_done = 1'b1;
        tick();
        check_val("wrap_pc", pc, 32'h0000_0000);
        check_val("wrap_fault", 32'(fault), 32'd0);

        // Reset during FETCH.
        do_reset(32'h0000_0100);
        run = 1'b1; bus.imem_ack = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check_val("rstf_state", 32'(state), 32'd0);
        check_val("rstf_pc", pc, 32'h0000_0100);
        check_val("rstf_iv", 32'(bus.instr_valid), 32'd0);

        // Reset in the cycle exec_done is seen, after one retired instruction.
        to_exec();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        tick();
        bus.exec_done = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h0000_0800;
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        check_val("rste_state", 32'(state), 32'd0);
        check_val("rste_pc", pc, 32'h0000_0100);
        check_val("rste_retired", retired, 32'd0);
        check_val("rste_iv", 32'(bus.instr_valid), 32'd0);

        // Random episodes.
        for (int ep = 0; ep < 30; ep++) begin
            case (ep % 5)
                0: ack_pct = 0;
                1: ack_pct = 10;
                2: ack_pct = 50;
                3: ack_pct = 90;
                default: ack_pct = 100;
            endcase
            do_reset((ep % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC));
            for (int c = 0; c < 60; c++) begin
                RESET = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                run = ($urandom_range(0, 1) == 1);
                bus.imem_ack = ($urandom_range(0, 99) < ack_pct);
                bus.imem_rdata = $urandom;
                bus.exec_done = ($urandom_range(0, 1) == 1);
                bus.halt = ($urandom_range(0, 99) < 4);
                bus.jump = ($urandom_range(0, 99) < 15);
                bus.branch_taken = ($urandom_range(0, 99) < 20);
                bus.jump_target = $urandom;
                if ($urandom_range(0, 3) != 0) bus.jump_target[1:0] = 2'b00;
                bus.branch_target = $urandom;
                if ($urandom_range(0, 3) != 0) bus.branch_target[1:0] = 2'b00;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the program counter register and drives the fetch/execute cycle of the processor. It requests instructions from instruction memory, holds each fetched instruction for the datapath, and waits for the datapath's completion strobe. It then selects the next PC from sequential, branch or jump sources, and detects halt, fetch-timeout and misaligned-target conditions.

## Interface
- XLEN, 32, address/instruction width
- FETCH_TIMEOUT, 16, max cycles in FETCH without imem_ack before fault (≥1)
- CLK  input  1  clock, rising edge active
- RESET  input  1  reset, synchronous, active-low
- start_pc  input  XLEN  PC loaded on reset
- run  input  1  permits leaving IDLE
- imem_req  output  1  fetch request, high exactly while in FETCH
- imem_addr  output  XLEN  equals pc
- imem_ack  input  1  fetch complete, rdata valid this cycle
- imem_rdata  input  XLEN  fetched instruction
- instr  output  XLEN  latched instruction
- instr_valid  output  1  one-cycle pulse on the cycle after a new instr is latched
- exec_done  input  1  datapath finished current instruction
- halt  input  1  qualified by exec_done: stop after this instruction
- jump, jump_target  input  1, XLEN  unconditional redirect
- branch_taken, branch_target  input  1, XLEN  conditional redirect
- pc  output  XLEN  current program counter
- retired  output  32  count of completed instructions, wraps
- halted  output  1  in HALTED
- fault  output  1  in FAULT
- state  output  3  current FSM state, for debug

## Operation
- States: IDLE, FETCH, EXEC, HALTED, FAULT.
- Reset (RESET==0 at a rising edge) has priority over everything and sets:
  - state=IDLE, pc=start_pc, instr=0, instr_valid=0, retired=0, internal timer=0.
  - halted=0, fault=0.
  - Reset mid-fetch or mid-exec aborts with no PC update.
- IDLE:
  - run=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - If imem_ack=1: instr←imem_rdata, timer←0, next state EXEC.
  - Else timer+1. When the timer reaches FETCH_TIMEOUT-1 without ack → FAULT.
  - An ack on the timeout cycle wins over the fault.
- EXEC: wait for exec_done, which is ignored in all other states. When exec_done=1:
  - Next-PC priority: halt > jump > branch_taken > pc+4.
  - halt: pc unchanged, retired+1, → HALTED.
  - jump or branch: target[1:0]≠0 → FAULT, pc unchanged, retired unchanged. Otherwise pc←target, retired+1, → FETCH.
  - Sequential: pc←pc+4, modulo 2^XLEN (0xFFFFFFFC wraps to 0), retired+1, → FETCH.
- HALTED and FAULT are terminal; only reset exits them.
- run is sampled only in IDLE.
- halted=1 iff state==HALTED; fault=1 iff state==FAULT.

## Timing
- imem_req, halted and fault are decoded from the registered state. No input reaches an output combinationally.
- Ack in the same cycle as the request:
  - FETCH lasts 1 cycle.
  - instr_valid is high during the first EXEC cycle.
- Minimum throughput: 2 cycles per instruction (FETCH 1 + EXEC 1).
- pc and retired update on the edge at which exec_done is sampled. The new pc appears on imem_addr in the following FETCH cycle.
- The timeout counter bounds FETCH to FETCH_TIMEOUT cycles, then fault asserts on the next edge.

## Structure
- Shared package pc_seq_pkg holds:
  - the state enum (3-bit encoding IDLE=0, FETCH=1, EXEC=2, HALTED=3, FAULT=4);
  - the PC_STEP=4 constant;
  - the alignment-mask constant.
- One natural sub-module, pc_next_sel: combinational next-PC priority mux plus misalignment flag.
- The FSM, PC register, timeout counter and retire counter live in pc_sequencer.

## Test plan
- Sequential run: RESET low one cycle, start_pc=0x100, run=1, immediate ack, exec_done each EXEC → imem_addr sequence 0x100, 0x104, 0x108; retired=3 after three instructions; instr_valid pulses 3 times.
- Redirects: at pc=0x200, jump=1 with jump_target=0x400 and branch_taken=1 with branch_target=0x300 in the same cycle → next imem_addr=0x400. Branch alone → 0x300.
- Halt and misalignment:
  - halt=1 with jump=1 → halted=1, pc stays 0x200, retired incremented, imem_req stays 0.
  - Separately, jump_target=0x402 → fault=1, pc unchanged.
- Fetch stall and timeout (FETCH_TIMEOUT=16):
  - Ack delayed 15 cycles → normal EXEC.
  - No ack → fault=1 after 16 FETCH cycles, imem_req deasserts.
- Wrap-around: start_pc=0xFFFFFFFC, sequential exec_done → pc=0x00000000, no fault.
- Reset mid-operation: assert RESET low during FETCH (and, separately, in the cycle exec_done=1) → next cycle state=IDLE, pc=start_pc, retired=0, instr_valid=0, no PC update applied.
